pool_seq_ctrl: RTL and testbench
================================

Name: pool_seq_ctrl

Overview:
- Sequencer for 2x2 / stride-2 max pooling over one square feature map held in a shared single-port RAM.
- Generates RAM read addresses for each window and reduces the four signed pixels to their maximum.
- Writes the pooled map back, row-major, to a destination region of the same RAM.
- Sits between the layer scheduler (start/done handshake) and the feature-map memory; replaces free-running pooling with address-driven sequencing.

Parameters:
- DATA_W, 16, pixel width (signed fixed point).
- ADDR_W, 12, RAM address width.
- SIZE_W, 6, width of map_size (maps up to 63x63).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- map_size  in  SIZE_W  map side length n; sampled with start.
- src_base  in  ADDR_W  address of pixel (0,0); sampled with start.
- dst_base  in  ADDR_W  address of first pooled output; sampled with start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse at job end.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  pooled value.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared.
- Reset mid-job aborts the job: no further rd_en or wr_en, no done pulse.
- Job geometry:
  - W = floor(n/2) windows per side.
  - Odd n drops the last row and last column.
  - n<2: accept, no reads or writes, done pulses the cycle after accept, busy never asserts.
- FSM states: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - start=1 latches n, src_base and dst_base, clears window row/col counters (wr, wc) and the output index k.
  - Next state is RD, or FIN if n<2.
- RD (4 cycles):
  - rd_en=1 each cycle.
  - Addresses, in order: src_base + 2wr·n + 2wc, +1, +n, +n+1.
- WAIT (1 cycle): final read datum returns.
- Running max:
  - The first returned datum loads the accumulator; each later datum replaces it if signed-greater.
  - Equal values keep the current value.
- WR (1 cycle):
  - wr_en=1, wr_addr = dst_base + k, wr_data = accumulator.
  - k increments; wc increments and wraps to 0 at W, incrementing wr.
  - Next state is RD, or FIN after window W·W−1.
- FIN (1 cycle): done=1, busy=0, then IDLE.
- Timing:
  - Each window takes 6 cycles.
  - Accept at edge T: busy high T+1 … T+6W².
  - Write for window k in cycle T+6+6k.
  - done in cycle T+6W²+1.
- start is ignored while busy.
- rd_en and wr_en are never high in the same cycle.
- Address arithmetic is modulo 2^ADDR_W; an address that wraps is the caller's error and is not checked.
- Products 2wr·n are computed at ADDR_W width.

Decomposition:
- Package pool_pkg holds:
  - DATA_W, ADDR_W, SIZE_W.
  - typedef logic signed [DATA_W-1:0] pix_t.
  - Enum state_t {IDLE, RD, WAIT, WR, FIN}.
- One sub-module, pool_max_acc: signed running-max register with load/update/clear inputs.
- Address generation and the FSM stay in pool_seq_ctrl.

Test Plan:
- Ascending map: n=4, src_base=0, pixel k = k. Required: writes to dst_base..+3 = 5, 7, 13, 15; done at T+25.
- Negative map: n=4, pixel k = −(k+1). Required: outputs −1, −3, −9, −11, confirming signed compare.
- Odd size: n=5, src_base=100.
  - Window 0 reads 100, 101, 105, 106.
  - Row 4 and column 4 never read.
  - Exactly 4 writes; done at T+25.
- Degenerate n=1: no rd_en or wr_en; done at T+1; busy stays 0.
- start pulsed at T+3 during a job: ignored; write count and done timing unchanged. After done, a new start is accepted.
- reset asserted in cycle T+8 (mid window 1): outputs 0 next cycle, no done, no further writes. A subsequent start restarts from window 0.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and widths for the 2x2 / stride-2 max-pooling sequencer.
package pool_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int SIZE_W = 6;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;
endpackage

// File: rtl/pool_max_acc.sv
// Signed running-max register: load takes the first pixel of a window,
// update keeps the larger of the stored and incoming pixel.
module pool_max_acc
  import pool_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic update,
  input  pix_t din,
  output pix_t q
);

  always_ff @(posedge clk) begin
    if (reset || clear)           q <= '0;
    else if (load)                q <= din;
    else if (update && (din > q)) q <= din;  // ties keep the stored value
  end

endmodule

// File: rtl/pool_seq_ctrl.sv
// Address-driven 2x2 max-pool sequencer: four reads per window, one write of
// the window maximum to dst_base + k, then a one-cycle done pulse.
module pool_seq_ctrl
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] map_size,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  pix_t              rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output pix_t              wr_data
);

  localparam int CW = SIZE_W - 1;

  state_t            state, state_d;
  logic [SIZE_W-1:0] n_q;
  logic [ADDR_W-1:0] src_q, dst_q, k_q;
  logic [CW-1:0]     wr_q, wc_q, w_n;
  logic [1:0]        ph_q;
  logic              rvld_q, rfirst_q;
  logic              last_win, accept;
  logic [ADDR_W-1:0] n_a, row_off, col_off, ph_off;
  pix_t              acc;

  assign w_n      = n_q[SIZE_W-1:1];
  assign last_win = (wr_q == w_n - CW'(1)) && (wc_q == w_n - CW'(1));
  assign accept   = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      IDLE: if (start) state_d = (map_size < SIZE_W'(2)) ? FIN : RD;
      RD: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (ph_q == 2'd3) state_d = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        state_d = WR;
      end
      WR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        state_d = last_win ? FIN : RD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q      <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      k_q      <= '0;
      wr_q     <= '0;
      wc_q     <= '0;
      ph_q     <= '0;
      rvld_q   <= 1'b0;
      rfirst_q <= 1'b0;
    end else begin
      // read data lags rd_en by one cycle; tag which beat opens a window
      rvld_q   <= rd_en;
      rfirst_q <= rd_en && (ph_q == 2'd0);
      case (state)
        IDLE: if (start) begin
          n_q   <= map_size;
          src_q <= src_base;
          dst_q <= dst_base;
          k_q   <= '0;
          wr_q  <= '0;
          wc_q  <= '0;
          ph_q  <= '0;
        end
        RD: ph_q <= ph_q + 2'd1;
        WR: begin
          k_q <= k_q + ADDR_W'(1);
          if (wc_q == w_n - CW'(1)) begin
            wc_q <= '0;
            wr_q <= wr_q + CW'(1);
          end else begin
            wc_q <= wc_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Window origin 2wr*n + 2wc, then +0, +1, +n, +n+1 across the four beats
  always_comb begin
    n_a     = ADDR_W'(n_q);
    row_off = ADDR_W'({wr_q, 1'b0}) * n_a;
    col_off = ADDR_W'({wc_q, 1'b0});
    ph_off  = (ph_q[1] ? n_a : '0) + ADDR_W'(ph_q[0]);
  end

  assign rd_addr = rd_en ? (src_q + row_off + col_off + ph_off) : '0;
  assign wr_addr = wr_en ? (dst_q + k_q) : '0;
  assign wr_data = wr_en ? acc : '0;

  pool_max_acc u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .load   (rvld_q && rfirst_q),
    .update (rvld_q),
    .din    (rd_data),
    .q      (acc)
  );

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl with a behavioural 1-cycle-latency RAM.
module tb_pool_seq_ctrl;
  import pool_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [SIZE_W-1:0] map_size = '0;
  logic [ADDR_W-1:0] src_base = '0, dst_base = '0;
  logic              busy, done, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  pix_t              rd_data = '0;
  pix_t              wr_data;

  int vec = 0, errs = 0;
  int cyc = 0;

  pix_t mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] rdq[$];
  logic [ADDR_W-1:0] waq[$];
  pix_t              wdq[$];
  int                wtq[$];
  int                done_cyc, busy_n, both_n;
  bit                done_seen;

  pool_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .map_size(map_size),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(negedge clk) begin
    if (rd_en) rdq.push_back(rd_addr);
    if (wr_en) begin
      waq.push_back(wr_addr);
      wdq.push_back(wr_data);
      wtq.push_back(cyc);
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (busy) busy_n++;
    if (rd_en && wr_en) both_n++;
  end

  task automatic clear_log();
    rdq.delete(); waq.delete(); wdq.delete(); wtq.delete();
    done_seen = 1'b0; done_cyc = 0; busy_n = 0; both_n = 0;
  endtask

  // Start a job; acc is the cycle count after the accepting edge, so a
  // cycle c observed at negedge is relative cycle c - acc + 1.
  task automatic run_job(input int n, input int src, input int dst,
                         input bit pulse, output int acc);
    @(posedge clk); #1;
    map_size = SIZE_W'(n); src_base = ADDR_W'(src); dst_base = ADDR_W'(dst);
    start = 1'b1;
    clear_log();
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done_seen) break;
      @(posedge clk); #1;
      start = pulse && (i + 1 == 3);
      if (start) map_size = SIZE_W'(2);
    end
    start = 1'b0;
    if (!done_seen) begin
      vec++; errs++;
      $display("FAIL job_timeout n=%0d: done never seen, required within 400 cycles", n);
    end
  endtask

  task automatic fill_ascending(input int base, input int n);
    for (int i = 0; i < n*n; i++) mem[base+i] = pix_t'(i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if ({busy, done, rd_en, wr_en} !== 4'b0) begin errs++;
      $display("FAIL reset_strobes got %b required 0000", {busy, done, rd_en, wr_en}); end
    vec++; if (rd_addr !== '0 || wr_addr !== '0) begin errs++;
      $display("FAIL reset_addr got rd=%0d wr=%0d required 0 0", rd_addr, wr_addr); end
    vec++; if (wr_data !== '0) begin errs++;
      $display("FAIL reset_wdata got %0d required 0", wr_data); end
    #1 reset = 1'b0;
  endtask

  task automatic test_ascending(input bit pulse, input int dst);
    int acc;
    int ex [4] = '{5, 7, 13, 15};
    fill_ascending(0, 4);
    run_job(4, 0, dst, pulse, acc);
    vec++; if (waq.size() != 4) begin errs++;
      $display("FAIL asc_wcount got %0d required 4", waq.size()); end
    for (int k = 0; k < 4 && k < waq.size(); k++) begin
      vec++; if (waq[k] !== ADDR_W'(dst + k) || wdq[k] !== pix_t'(ex[k])) begin errs++;
        $display("FAIL asc_write%0d got addr=%0d data=%0d required addr=%0d data=%0d",
                 k, waq[k], wdq[k], dst + k, ex[k]); end
      vec++; if (wtq[k] - acc + 1 != 6 + 6*k) begin errs++;
        $display("FAIL asc_wtime%0d got T+%0d required T+%0d", k, wtq[k]-acc+1, 6+6*k); end
    end
    vec++; if (done_cyc - acc + 1 != 25) begin errs++;
      $display("FAIL asc_done got T+%0d required T+25", done_cyc - acc + 1); end
    vec++; if (busy_n != 24) begin errs++;
      $display("FAIL asc_busy got %0d cycles required 24", busy_n); end
    vec++; if (rdq.size() != 16 || both_n != 0) begin errs++;
      $display("FAIL asc_reads got reads=%0d overlap=%0d required 16 0", rdq.size(), both_n); end
  endtask

  task automatic test_negative();
    int acc;
    int ex [4] = '{-1, -3, -9, -11};
    for (int i = 0; i < 16; i++) mem[i] = pix_t'(-(i+1));
    run_job(4, 0, 300, 1'b0, acc);
    vec++; if (waq.size() != 4) begin errs++;
      $display("FAIL neg_wcount got %0d required 4", waq.size()); end
    for (int k = 0; k < 4 && k < waq.size(); k++) begin
      vec++; if (wdq[k] !== pix_t'(ex[k]) || waq[k] !== ADDR_W'(300 + k)) begin errs++;
        $display("FAIL neg_write%0d got addr=%0d data=%0d required addr=%0d data=%0d",
                 k, waq[k], wdq[k], 300 + k, ex[k]); end
    end
  endtask

  task automatic test_odd_size();
    int acc, bad;
    int ex [4] = '{6, 8, 16, 18};
    int er [4] = '{100, 101, 105, 106};
    for (int i = 0; i < 25; i++)
      mem[100+i] = ((i / 5 == 4) || (i % 5 == 4)) ? pix_t'(1000) : pix_t'(i);
    run_job(5, 100, 400, 1'b0, acc);
    for (int k = 0; k < 4 && k < rdq.size(); k++) begin
      vec++; if (rdq[k] !== ADDR_W'(er[k])) begin errs++;
        $display("FAIL odd_raddr%0d got %0d required %0d", k, rdq[k], er[k]); end
    end
    bad = 0;
    foreach (rdq[i]) begin
      int off = int'(rdq[i]) - 100;
      if (off < 0 || off > 24 || off / 5 == 4 || off % 5 == 4) bad++;
    end
    vec++; if (bad != 0 || rdq.size() != 16) begin errs++;
      $display("FAIL odd_reads got bad=%0d count=%0d required 0 16", bad, rdq.size()); end
    vec++; if (waq.size() != 4) begin errs++;
      $display("FAIL odd_wcount got %0d required 4", waq.size()); end
    for (int k = 0; k < 4 && k < wdq.size(); k++) begin
      vec++; if (wdq[k] !== pix_t'(ex[k])) begin errs++;
        $display("FAIL odd_wdata%0d got %0d required %0d", k, wdq[k], ex[k]); end
    end
    vec++; if (done_cyc - acc + 1 != 25) begin errs++;
      $display("FAIL odd_done got T+%0d required T+25", done_cyc - acc + 1); end
  endtask

  task automatic test_degenerate();
    int acc;
    run_job(1, 0, 500, 1'b0, acc);
    vec++; if (rdq.size() != 0 || waq.size() != 0) begin errs++;
      $display("FAIL deg_access got reads=%0d writes=%0d required 0 0", rdq.size(), waq.size()); end
    vec++; if (done_cyc - acc + 1 != 1) begin errs++;
      $display("FAIL deg_done got T+%0d required T+1", done_cyc - acc + 1); end
    vec++; if (busy_n != 0) begin errs++;
      $display("FAIL deg_busy got %0d cycles required 0", busy_n); end
  endtask

  task automatic test_back_to_back();
    int acc;
    test_ascending(1'b1, 200);
    run_job(2, 0, 220, 1'b0, acc);
    vec++; if (waq.size() != 1 || wdq[0] !== pix_t'(3) || waq[0] !== ADDR_W'(220)) begin errs++;
      $display("FAIL b2b_n2 got writes=%0d data=%0d addr=%0d required 1 3 220",
               waq.size(), wdq.size() > 0 ? wdq[0] : pix_t'(0), waq.size() > 0 ? waq[0] : '0); end
    vec++; if (done_cyc - acc + 1 != 7) begin errs++;
      $display("FAIL b2b_done got T+%0d required T+7", done_cyc - acc + 1); end
  endtask

  task automatic test_reset_midjob();
    int acc;
    fill_ascending(0, 4);
    @(posedge clk); #1;
    map_size = SIZE_W'(4); src_base = '0; dst_base = ADDR_W'(600); start = 1'b1;
    clear_log();
    @(posedge clk); #1;
    acc = cyc; start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vec++; if ({busy, done, rd_en, wr_en} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0) begin errs++;
      $display("FAIL rst_mid_out got strobes=%b rd=%0d wr=%0d required 0", {busy, done, rd_en, wr_en},
               rd_addr, wr_addr); end
    repeat (40) @(negedge clk);
    vec++; if (waq.size() != 1 || rdq.size() != 6) begin errs++;
      $display("FAIL rst_mid_acc got writes=%0d reads=%0d required 1 6", waq.size(), rdq.size()); end
    vec++; if (done_seen) begin errs++;
      $display("FAIL rst_mid_done got done at T+%0d required none", done_cyc - acc + 1); end
    run_job(4, 0, 240, 1'b0, acc);
    vec++; if (waq.size() != 4 || waq[0] !== ADDR_W'(240) || wdq[0] !== pix_t'(5)) begin errs++;
      $display("FAIL rst_restart got writes=%0d first addr=%0d data=%0d required 4 240 5",
               waq.size(), waq.size() > 0 ? waq[0] : '0, wdq.size() > 0 ? wdq[0] : pix_t'(0)); end
  endtask

  initial begin
    test_reset();
    test_ascending(1'b0, 200);
    test_negative();
    test_odd_size();
    test_degenerate();
    test_back_to_back();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
